// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared definitions for the sipo_rx serial frame receiver.
//   state_t     : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   START_LEVEL : line level of a start bit
//   STOP_LEVEL  : line level of a valid stop bit
//   IDLE_LEVEL  : line level while no frame is in flight
package sipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage : sipo_pkg

// File: rtl/sipo_shreg.sv
// sipo_shreg -- N-bit serial-in shift register with enable and sync clear.
// Parameters:
//   N         : register width
//   MSB_FIRST : 0 = shift right, insert at bit N-1 (first bit ends in [0])
//               1 = shift left, insert at bit 0   (first bit ends in [N-1])
// Ports:
//   i_clk  : clock, rising edge
//   i_clr  : synchronous clear (highest priority)
//   i_en   : shift enable
//   i_bit  : serial bit to insert
//   o_data : current register contents
module sipo_shreg #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [N-1:0] o_data
);

    logic [N-1:0] r_data;
    logic [N-1:0] w_next;

    generate
        if (MSB_FIRST) begin : g_left
            assign w_next = {r_data[N-2:0], i_bit};
        end else begin : g_right
            assign w_next = {i_bit, r_data[N-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule : sipo_shreg

// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in / parallel-out frame receiver.
// Frame: start bit (0), N data bits, [parity bit], stop bit (1).
// SIN is sampled only on EN cycles. The received word is presented on Q
// with a VALID/ACK handshake.
// Optional build macro: SIPO_RX_PARITY_EN adds an even-parity bit after
// the data bits and the PARITY_ERR output.
// Parameters:
//   N         : data bits per frame (2..32)
//   MSB_FIRST : 0 = first data bit lands in Q[0], 1 = in Q[N-1]
// Ports:
//   CLK        : clock, rising edge
//   RESET      : synchronous active-high reset
//   EN         : bit strobe
//   SIN        : serial input, idle high
//   ACK        : consumer accepts Q while VALID=1
//   Q          : received word (registered)
//   VALID      : Q holds an unacknowledged word
//   BUSY       : a frame is in progress
//   FRAME_ERR  : one-cycle pulse, stop bit sampled low
//   OVERRUN    : sticky, a good frame replaced an unacknowledged word
//   PARITY_ERR : one-cycle pulse, parity mismatch (macro builds only)
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EN,
    input  logic         SIN,
    input  logic         ACK,
    output logic [N-1:0] Q,
    output logic         VALID,
    output logic         BUSY,
    output logic         FRAME_ERR,
    output logic         OVERRUN
`ifdef SIPO_RX_PARITY_EN
    ,
    output logic         PARITY_ERR
`endif
);

    localparam int unsigned  CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_q;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;
    logic [N-1:0]  w_word;
    logic          w_shift;
    logic          w_par_ok;

`ifdef SIPO_RX_PARITY_EN
    logic          r_par;
    logic          r_perr;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_ok = ~((^w_word) ^ r_par);
    assign PARITY_ERR = r_perr;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_shift = EN && (r_state == ST_DATA);

    sipo_shreg #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .i_clk  (CLK),
        .i_clr  (RESET),
        .i_en   (w_shift),
        .i_bit  (SIN),
        .o_data (w_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            // ACK is honoured regardless of EN; a good frame completing
            // in the same cycle overrides this clear further below.
            if (r_valid && ACK) begin
                r_valid <= 1'b0;
            end

            if (EN) begin
                case (r_state)
                    ST_IDLE: begin
                        if (SIN == START_LEVEL) begin
                            r_state <= ST_DATA;
                            r_cnt   <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BIT) begin
`ifdef SIPO_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
`ifdef SIPO_RX_PARITY_EN
                    ST_PARITY: begin
                        r_par   <= SIN;
                        r_state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        // Stop-bit cycle is never reused as a start bit.
                        r_state <= ST_IDLE;
                        if (SIN == STOP_LEVEL) begin
                            if (w_par_ok) begin
                                r_q     <= w_word;
                                r_valid <= 1'b1;
                                if (r_valid && !ACK) begin
                                    r_ovr <= 1'b1;
                                end
                            end else begin
`ifdef SIPO_RX_PARITY_EN
                                r_perr <= 1'b1;
`endif
                            end
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Q         = r_q;
    assign VALID     = r_valid;
    assign BUSY      = (r_state != ST_IDLE);
    assign FRAME_ERR = r_ferr;
    assign OVERRUN   = r_ovr;

endmodule : sipo_rx

// File: tb/tb_sipo_rx.sv
`timescale 1ns/1ps
module tb_sipo_rx;
    import sipo_pkg::*;

    localparam int unsigned N = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         EN;
    logic         SIN;
    logic         ACK;
    logic [N-1:0] Q;
    logic         VALID;
    logic         BUSY;
    logic         FRAME_ERR;
    logic         OVERRUN;
`ifdef SIPO_RX_PARITY_EN
    logic         PARITY_ERR;
`endif

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] sb[$];

    sipo_rx #(
        .N         (N),
        .MSB_FIRST (1'b0)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .SIN       (SIN),
        .ACK       (ACK),
        .Q         (Q),
        .VALID     (VALID),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
`ifdef SIPO_RX_PARITY_EN
        ,
        .PARITY_ERR(PARITY_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // gap EN=0 cycles with SIN wiggling, then one EN cycle carrying b.
    task automatic put_bit(input logic b, input int unsigned gap, input logic ack);
        for (int unsigned i = 0; i < gap; i++) begin
            EN  = 1'b0;
            SIN = ~SIN;
            tick();
        end
        EN  = 1'b1;
        SIN = b;
        ACK = ack;
        tick();
        ACK = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop,
                              input int unsigned gap, input logic par_flip,
                              input logic ack_stop);
        logic good;
        put_bit(START_LEVEL, gap, 1'b0);
        for (int i = 0; i < int'(N); i++) begin
            put_bit(d[i], gap, 1'b0);
        end
        good = (stop == STOP_LEVEL);
`ifdef SIPO_RX_PARITY_EN
        put_bit((^d) ^ par_flip, gap, 1'b0);
        good = good && !par_flip;
`endif
        put_bit(stop, gap, ack_stop);
        if (good) begin
            sb.push_back(d);
        end
        EN  = 1'b0;
        SIN = IDLE_LEVEL;
    endtask

    task automatic check_word(input string tag);
        logic [N-1:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_q"}, Q, exp);
            chk({tag, "_valid"}, VALID, 1'b1);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        EN    = 1'b0;
        SIN   = IDLE_LEVEL;
        ACK   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        EN    = 1'b0;
        SIN   = IDLE_LEVEL;
        ACK   = 1'b0;
        do_reset();
        chk("rst_q", Q, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ferr", FRAME_ERR, 0);
        chk("rst_ovr", OVERRUN, 0);

        // Basic frame A5, EN every cycle.
        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        check_word("a5");
        chk("a5_busy", BUSY, 0);
        chk("a5_ferr", FRAME_ERR, 0);

        // Framing error from a clean reset state.
        do_reset();
        put_bit(START_LEVEL, 0, 1'b0);
        chk("busy_mid", BUSY, 1);
        for (int i = 0; i < int'(N); i++) put_bit(((8'hA5 >> i) & 8'h01) != 0, 0, 1'b0);
`ifdef SIPO_RX_PARITY_EN
        put_bit(^8'hA5, 0, 1'b0);
`endif
        put_bit(1'b0, 0, 1'b0);
        EN  = 1'b0;
        SIN = IDLE_LEVEL;
        chk("ferr_pulse", FRAME_ERR, 1);
        chk("ferr_q", Q, 0);
        chk("ferr_valid", VALID, 0);
        chk("ferr_busy", BUSY, 0);
        tick();
        chk("ferr_clear", FRAME_ERR, 0);
        send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
        check_word("3c");

        // ACK clears VALID, Q held; ACK with VALID=0 ignored.
        do_ack();
        chk("ack_valid", VALID, 0);
        chk("ack_q_hold", Q, 8'h3C);
        do_ack();
        chk("ack_idle_valid", VALID, 0);

        // Overrun.
        send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
        check_word("11");
        chk("11_ovr", OVERRUN, 0);
        send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
        check_word("22_ovr");
        chk("22_ovr_set", OVERRUN, 1);
        tick();
        chk("ovr_sticky", OVERRUN, 1);

        // Completion coinciding with ACK: no overrun.
        do_reset();
        chk("rst2_ovr", OVERRUN, 0);
        send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
        check_word("11b");
        send_frame(8'h22, 1'b1, 0, 1'b0, 1'b1);
        check_word("22_ack");
        chk("22_ack_ovr", OVERRUN, 0);
        do_ack();

        // Sparse strobes: EN one cycle in four, SIN toggling in between.
        send_frame(8'hF0, 1'b1, 3, 1'b0, 1'b0);
        check_word("f0_sparse");
        do_ack();

        // Reset mid-frame after the 4th data bit.
        put_bit(START_LEVEL, 0, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b1, 0, 1'b0);
        chk("mid_busy", BUSY, 1);
        RESET = 1'b1;
        EN    = 1'b1;
        SIN   = 1'b0;
        tick();
        RESET = 1'b0;
        EN    = 1'b0;
        SIN   = IDLE_LEVEL;
        chk("mid_rst_q", Q, 0);
        chk("mid_rst_valid", VALID, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_ferr", FRAME_ERR, 0);
        chk("mid_rst_ovr", OVERRUN, 0);
        send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b0);
        check_word("5a");
        do_ack();

`ifdef SIPO_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0);
        check_word("par_ok");
        chk("par_ok_perr", PARITY_ERR, 0);
        do_ack();
        send_frame(8'h07, 1'b1, 0, 1'b1, 1'b0);
        chk("par_bad_perr", PARITY_ERR, 1);
        chk("par_bad_valid", VALID, 0);
        chk("par_bad_ferr", FRAME_ERR, 0);
        tick();
        chk("par_bad_clear", PARITY_ERR, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sipo_rx

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in, parallel-out frame receiver; companion to the team's PISO transmitter.
- Frame format: start bit, N data bits, stop bit.
- Samples SIN on bit-strobe cycles, rebuilds the N-bit word and presents it on Q with a VALID/ACK handshake.
- Flags framing errors and overruns. Sits between a serial line and a parallel consumer.

Parameters:
- N, 8, data bits per frame (2..32).
- MSB_FIRST, 0, 0 = first data bit is Q[0]; 1 = first data bit is Q[N-1].

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  bit strobe; SIN is sampled only on cycles with EN=1.
- SIN  input  1  serial data; idle level 1.
- ACK  input  1  consumer accepts Q while VALID=1.
- Q  output  N  received word; registered.
- VALID  output  1  Q holds an unacknowledged word.
- BUSY  output  1  a frame is in progress (state not IDLE).
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled as 0.
- OVERRUN  output  1  sticky: a completed frame was lost because VALID was still 1.

Behaviour:
- Reset (RESET=1 at rising CLK): Q=0, VALID=0, BUSY=0, FRAME_ERR=0, OVERRUN=0, state=IDLE, bit count=0, shift register=0. Reset overrides all other inputs. Reset mid-frame abandons the frame.
- EN=0 cycles: FSM, shift register and bit counter hold. ACK is still honoured. FRAME_ERR returns to 0.
- FSM states: IDLE, DATA, STOP.
  - IDLE: on EN and SIN=0, go to DATA, count=0. SIN=1 stays in IDLE.
  - DATA: each EN cycle shifts SIN in and increments count. After the Nth data bit, go to STOP.
  - STOP (next EN cycle):
    - SIN=1: frame good. Load Q from the shift register, set VALID=1, return to IDLE.
    - SIN=0: FRAME_ERR=1 for one cycle. Q and VALID unchanged. Return to IDLE.
- The stop bit's EN cycle is never treated as a start bit. The next start bit can be sampled on the next EN cycle after STOP.
- Latency: Q/VALID update on the rising edge that samples a good stop bit; visible the following cycle.
- Bit order:
  - MSB_FIRST=0: shift right, insert at bit N-1. After N bits the first-received bit is in Q[0].
  - MSB_FIRST=1: shift left, insert at bit 0.
- Handshake:
  - ACK=1 with VALID=1 clears VALID next cycle.
  - ACK while VALID=0 is ignored.
  - Q keeps its value after ACK until the next good frame.
- Good frame completes while VALID=1 and ACK=0: Q is overwritten with the new word, VALID stays 1, OVERRUN set to 1. OVERRUN clears only on RESET.
- Good frame completes in the same cycle as ACK=1: Q loads the new word, VALID stays 1, OVERRUN not set.
- Bit counter width is $clog2(N+1). The counter never wraps within a frame.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP; one extra bit per frame, even parity over the N data bits plus the parity bit.
  - Parity mismatch with a good stop bit: PARITY_ERR output pulses for one cycle. Q is not loaded and VALID is unchanged.
  - Port PARITY_ERR exists only when the macro is defined.
- Undefined: no PARITY state, no PARITY_ERR port; frame is N+2 bits.

Decomposition:
- Package sipo_pkg:
  - state enum typedef (IDLE, DATA, PARITY, STOP).
  - START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
- One sub-module, sipo_shreg: N-bit shift register with enable, direction set by MSB_FIRST, synchronous clear. The FSM, counter and handshake live in sipo_rx.

Test Plan:
- N=8, MSB_FIRST=0, EN=1 every cycle. Send 0, 1,0,1,0,0,1,0,1, 1 -> Q=8'hA5, VALID=1 the cycle after the stop bit, BUSY=0.
- Same frame with stop bit 0 -> FRAME_ERR pulses one cycle; Q stays 0, VALID stays 0; next good frame 8'h3C received correctly.
- Receive 8'h11 with no ACK, then 8'h22 -> Q=8'h22, VALID=1, OVERRUN=1. Repeat with ACK high on the completion cycle of 8'h22 -> OVERRUN stays 0.
- EN high one cycle in four while sending 8'hF0 -> Q=8'hF0. SIN toggling on EN=0 cycles has no effect.
- RESET=1 after the 4th data bit, then a full 8'h5A frame -> all outputs 0 after reset; Q=8'h5A afterwards.
- SIPO_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> VALID=1, Q=8'h07. With parity bit 0 -> PARITY_ERR pulse, VALID stays 0.
